// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the ALU sharing controller and the ALU itself:
//   - 4-bit opcodes in the alu_opsel encoding
//   - controller state enum (IDLE, EXEC, DONE)
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_NOT   = 4'b1011;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    localparam logic [3:0] OP_SHL   = 4'b1101;
    localparam logic [3:0] OP_PASS  = 4'b0100;
    localparam logic [3:0] OP_PASS2 = 4'b0110;
    localparam logic [3:0] OP_ZERO  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/alu_32bit.sv
// alu_32bit
// Single-pass 32-bit combinational ALU. SHL shifts reg_1 left by exactly one
// bit; multi-bit shifts are built by the controller from repeated passes.
// Ports:
//   reg_1     : in  [31:0] operand A
//   reg_2     : in  [31:0] operand B
//   alu_opsel : in  [3:0]  opcode (alu_ctrl_pkg encoding)
//   alu_out   : out [31:0] result; unknown opcodes give 0
module alu_32bit
    import alu_ctrl_pkg::*;
(
    input  logic [31:0] reg_1,
    input  logic [31:0] reg_2,
    input  logic [3:0]  alu_opsel,
    output logic [31:0] alu_out
);

    always_comb begin
        alu_out = 32'h0;
        case (alu_opsel)
            OP_ADD:   alu_out = reg_1 + reg_2;
            OP_SUB:   alu_out = reg_1 - reg_2;
            OP_AND:   alu_out = reg_1 & reg_2;
            OP_OR:    alu_out = reg_1 | reg_2;
            OP_NOT:   alu_out = ~reg_1;
            OP_XOR:   alu_out = reg_1 ^ reg_2;
            OP_SHL:   alu_out = {reg_1[30:0], 1'b0};
            OP_PASS:  alu_out = reg_1;
            OP_PASS2: alu_out = reg_1;
            OP_ZERO:  alu_out = 32'h0;
            default:  alu_out = 32'h0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Shares one alu_32bit between two requesters. One command is in flight at a
// time; grants are round-robin. SHL by N runs N one-bit passes through the ALU.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/ready    : per-requester command handshake (ready is one-hot or 0)
//   req_op/a/b/shamt   : per-requester command fields
//   res_valid/ready    : result handshake
//   res_data, res_id   : result and the index of the issuing requester
//   busy               : high whenever the controller is not IDLE
//   dbg_state          : current controller state
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. A source holds valid and its payload stable until the transfer;
// res_valid is never withdrawn before res_ready.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int SHAMT_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0][3:0]          req_op,
    input  logic [1:0][31:0]         req_a,
    input  logic [1:0][31:0]         req_b,
    input  logic [1:0][SHAMT_W-1:0]  req_shamt,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic                     res_id,
    output logic                     busy,
    output ctrl_state_t              dbg_state
);

    ctrl_state_t        state;
    logic [3:0]         op_q;
    logic [31:0]        acc;
    logic [31:0]        b_q;
    logic [SHAMT_W-1:0] cnt;
    logic               last;
    logic               grant;
    logic               accept;
    logic [3:0]         alu_sel;
    logic [31:0]        alu_out;

    // Tie goes to the requester not served last; otherwise whoever is valid.
    function automatic logic rr_grant(input logic [1:0] valid, input logic last_g);
        if (valid == 2'b11)
            return !last_g;
        else
            return valid[1];
    endfunction

    assign grant = rr_grant(req_valid, last);

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && rst_n)
            req_ready = req_valid & (grant ? 2'b10 : 2'b01);
    end

    assign accept = |req_ready;

    // A zero-length shift must still produce a once through the ALU.
    assign alu_sel = (op_q == OP_SHL && cnt == '0) ? OP_PASS : op_q;

    alu_32bit u_alu (
        .reg_1     (acc),
        .reg_2     (b_q),
        .alu_opsel (alu_sel),
        .alu_out   (alu_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= 4'h0;
            acc       <= 32'h0;
            b_q       <= 32'h0;
            cnt       <= '0;
            last      <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= 32'h0;
            res_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= req_op[grant];
                        acc    <= req_a[grant];
                        b_q    <= req_b[grant];
                        cnt    <= req_shamt[grant];
                        res_id <= grant;
                        last   <= grant;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q == OP_SHL && cnt > SHAMT_W'(1)) begin
                        acc <= alu_out;
                        cnt <= cnt - SHAMT_W'(1);
                    end else begin
                        res_data  <= alu_out;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
// Bench for alu_share_ctrl: per-requester command queues, a behavioural
// reference (result, latency, round-robin grant) and an expected-result queue.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    localparam int SHAMT_W = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]              req_valid = 2'b00;
    logic [1:0]              req_ready;
    logic [1:0][3:0]         req_op = '0;
    logic [1:0][31:0]        req_a = '0;
    logic [1:0][31:0]        req_b = '0;
    logic [1:0][SHAMT_W-1:0] req_shamt = '0;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic [31:0]             res_data;
    logic                    res_id;
    logic                    busy;
    ctrl_state_t             dbg_state;

    alu_share_ctrl #(.SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_shamt (req_shamt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- model state ----------------
    typedef struct packed {
        logic [3:0]         op;
        logic [31:0]        a;
        logic [31:0]        b;
        logic [SHAMT_W-1:0] sh;
    } cmd_t;

    cmd_t        q0[$];
    cmd_t        q1[$];
    logic [32:0] exp_q[$];   // {id, data}
    int          due_q[$];   // step at which res_valid must first be seen
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          outstanding = 1'b0;
    bit          last_m = 1'b1;
    int          rr_mode = 0;  // 0: always ready, 1: random, 2: stall then ready
    int          stall_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (step %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] ref_result(input cmd_t c);
        case (c.op)
            4'b0000: return c.a + c.b;
            4'b0011: return c.a - c.b;
            4'b1000: return c.a & c.b;
            4'b1001: return c.a | c.b;
            4'b1011: return ~c.a;
            4'b1010: return c.a ^ c.b;
            4'b1101: return (int'(c.sh) >= 32) ? 32'h0 : (c.a << c.sh);
            4'b0100: return c.a;
            4'b0110: return c.a;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input cmd_t c);
        if (c.op == 4'b1101 && c.sh != 0)
            return 1 + int'(c.sh);
        return 2;
    endfunction

    // ---------------- driver + scoreboard, one clock per call ----------------
    task automatic tick();
        logic       g;
        logic [1:0] exp_rdy;
        logic       exp_rv;
        cmd_t       c;
        @(negedge clk);
        cyc++;
        req_valid[0] = (q0.size() > 0);
        req_valid[1] = (q1.size() > 0);
        if (req_valid[0]) begin
            c = q0[0];
            req_op[0] = c.op; req_a[0] = c.a; req_b[0] = c.b; req_shamt[0] = c.sh;
        end else begin
            req_op[0] = 4'($urandom); req_a[0] = $urandom; req_b[0] = $urandom;
        end
        if (req_valid[1]) begin
            c = q1[0];
            req_op[1] = c.op; req_a[1] = c.a; req_b[1] = c.b; req_shamt[1] = c.sh;
        end else begin
            req_op[1] = 4'($urandom); req_a[1] = $urandom; req_b[1] = $urandom;
        end
        case (rr_mode)
            0: res_ready = 1'b1;
            1: res_ready = 1'($urandom_range(0, 1));
            default: begin
                res_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
        endcase
        #1;
        g = (req_valid == 2'b11) ? !last_m : req_valid[1];
        exp_rdy = (!outstanding && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
        exp_rv = outstanding && (due_q.size() > 0) && (cyc >= due_q[0]);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(outstanding));
        check("res_valid", 32'(res_valid), 32'(exp_rv));
        if (exp_rv) begin
            check("res_data", res_data, exp_q[0][31:0]);
            check("res_id", 32'(res_id), 32'(exp_q[0][32]));
        end
        if (exp_rdy != 2'b00) begin
            c = g ? q1.pop_front() : q0.pop_front();
            exp_q.push_back({g, ref_result(c)});
            due_q.push_back(cyc + ref_latency(c));
            outstanding = 1'b1;
            last_m = g;
        end else if (exp_rv && res_ready) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            outstanding = 1'b0;
        end
    endtask

    task automatic push_cmd(input int r, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [SHAMT_W-1:0] sh);
        cmd_t c;
        c.op = op; c.a = a; c.b = b; c.sh = sh;
        if (r == 0) q0.push_back(c); else q1.push_back(c);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || outstanding) && k < 800) begin
            tick();
            k++;
        end
        check("drain_timeout", 32'(k < 800), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"}, res_data, 32'd0);
        check({tag, "_res_id"}, 32'(res_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k;
        req_valid = 2'b11;
        #3;
        check_reset_outputs("rst");
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;

        // ADD wraps: 0xFFFFFFFF + 2 = 1
        push_cmd(0, OP_ADD, 32'hFFFF_FFFF, 32'd2, '0);
        drain();

        // Both requesters contending with SUB: grants alternate
        rr_mode = 0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, OP_SUB, 32'd10, 32'd3, '0);
            push_cmd(1, OP_SUB, 32'd3, 32'd10, '0);
        end
        drain();

        // SHL by 4 and by 0 from requester 1
        push_cmd(1, OP_SHL, 32'h3, 32'h0, 5'd4);
        push_cmd(1, OP_SHL, 32'hDEAD_BEEF, 32'h1, 5'd0);
        push_cmd(0, OP_SHL, 32'h8000_0001, 32'h0, 5'd31);
        drain();

        // Backpressure in DONE with a pending requester 1 command
        rr_mode = 2;
        stall_left = 12;
        push_cmd(0, OP_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000, '0);
        push_cmd(1, OP_OR, 32'h1200_0034, 32'h0056_7800, '0);
        drain();
        rr_mode = 0;

        // Undefined opcode, NOT, ZERO, PASS alias
        push_cmd(0, 4'b0001, 32'd5, 32'd5, '0);
        push_cmd(1, OP_NOT, 32'h0, 32'h1234, '0);
        push_cmd(0, OP_ZERO, 32'h55, 32'h66, '0);
        push_cmd(1, OP_PASS2, 32'hCAFE_F00D, 32'h0, '0);
        push_cmd(0, OP_AND, 32'hF0F0_F0F0, 32'h3C3C_3C3C, '0);
        drain();

        // Reset in the middle of a long shift; req1 last granted so a tie
        // would go to req0 anyway -- make req1 the last winner first.
        push_cmd(1, OP_ADD, 32'd1, 32'd1, '0);
        drain();
        push_cmd(1, OP_SHL, 32'h1, 32'h0, 5'd20);
        k = 0;
        while (!outstanding && k < 20) begin tick(); k++; end
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        check_reset_outputs("midrst");
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        outstanding = 1'b0;
        exp_q.delete();
        due_q.delete();
        last_m = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;
        push_cmd(0, OP_ADD, 32'd7, 32'd8, '0);
        push_cmd(1, OP_SUB, 32'd7, 32'd8, '0);
        tick();
        check("tie_after_reset", 32'(req_ready), 32'd1);
        drain();

        // Randomized traffic with random result backpressure
        rr_mode = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0)
                push_cmd(0, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 2) == 0)
                push_cmd(1, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing arbiter that shares one `alu_32bit` datapath between two requesters. It accepts one command at a time under round-robin arbitration and drives the ALU from latched operands. Single-pass ops finish in one cycle. Shift-left-by-N is built from repeated 1-bit `SHL` passes. Each result is returned on a valid/ready channel tagged with the requester ID.

## Interface
Parameters:
- `SHAMT_W`, default 5: width of the shift-amount field; the maximum shift is 2^SHAMT_W−1.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `req_valid`: input, [1:0]. Per-requester command valid.
- `req_ready`: output, [1:0]. Per-requester accept; at most one bit is high in any cycle.
- `req_op`: input, [1:0][3:0]. ALU opcode per requester, in `alu_opsel` encoding.
- `req_a`: input, [1:0][31:0]. Operand A per requester.
- `req_b`: input, [1:0][31:0]. Operand B per requester.
- `req_shamt`: input, [1:0][SHAMT_W-1:0]. Shift count; used only when `req_op` = SHL (4'b1101).
- `res_valid`: output, 1 bit. Result valid.
- `res_ready`: input, 1 bit. Consumer accept.
- `res_data`: output, [31:0]. Result.
- `res_id`: output, 1 bit. Index of the requester that issued the command.
- `busy`: output, 1 bit. High in every state except IDLE.

## Operation
Opcodes:
- ADD 0000, SUB 0011, AND 1000, OR 1001, NOT 1011, XOR 1010, SHL 1101, PASS 0100/0110, ZERO 1111.
- Any other code yields 0, matching the ALU default.

State machine:
- **IDLE**:
  - `req_ready[g]` = `req_valid[g]`, where g is the grant.
  - On handshake: latch op, a, b, shamt and id = g; go to EXEC.
- **EXEC**:
  - ALU `reg_1` = accumulator `acc`; `reg_2` = latched b; `alu_opsel` = latched op.
  - Non-SHL op: `res_data` ← ALU output; go to DONE.
  - SHL with `cnt` > 1: `acc` ← ALU output; `cnt` decrements.
  - SHL with `cnt` = 1: `res_data` ← ALU output; go to DONE.
  - SHL with shamt = 0: EXEC drives PASS (0100), so `res_data` = a; one cycle.
- **DONE**:
  - `res_valid` = 1; `res_data` and `res_id` are held stable.
  - On `res_ready`: go to IDLE.

Arbitration:
- Round-robin over 2 requesters. `last` = the most recently granted index.
- If both requesters are valid, grant `!last`. Otherwise grant whichever one is valid.
- `last` updates only on an accepted handshake.
- Reset value of `last` = 1, so requester 0 wins the first tie.

Arithmetic:
- All ALU widths are 32 bits. ADD and SUB wrap modulo 2^32; no carry or overflow flag.
- SHL by N ≥ 32 yields 0.

## Timing
Reset (asynchronous, any state):
- State → IDLE.
- `req_ready` = 0, `res_valid` = 0, `res_data` = 0, `res_id` = 0, `busy` = 0.
- `acc` = 0, `cnt` = 0, `last` = 1.
- Any in-flight command is dropped, with no result.

Latency and throughput:
- Handshake in cycle T. Single-pass op: `res_valid` rises at T+2.
- SHL by N ≥ 1: `res_valid` rises at T+1+N.
- DONE→IDLE takes one cycle after `res_ready`. The next accept is at the earliest in the cycle after that.
- Peak throughput: one single-pass op per 3 cycles.

Handshake rules:
- `req_ready` is 0 in EXEC and DONE; requests wait and are not dropped.
- `req_valid` may depend on nothing the block drives. `req_ready` depends combinationally on `req_valid`.
- Requesters hold op/a/b/shamt stable while valid and not yet accepted.
- `res_valid` stays high until `res_ready`; it is never withdrawn.

Simultaneous events:
- `res_ready` together with new `req_valid` while in DONE: there is no accept in that cycle; the new request is accepted in the following IDLE cycle.

## Structure
- Shared package `alu_ctrl_pkg`:
  - 4-bit opcode localparams (ADD, SUB, AND, OR, NOT, XOR, SHL, PASS, ZERO).
  - State enum {IDLE, EXEC, DONE}.
- One sub-module: the existing `alu_32bit`, instantiated once. All sequencing, arbitration and registers live in `alu_share_ctrl`.
- The round-robin grant is a small combinational function inside the module; it is not a separate module.

## Test plan
- Reset, then ADD from req0: a=0xFFFF_FFFF, b=2, accepted at T → `res_valid` at T+2, `res_data`=0x0000_0001, `res_id`=0.
- Both valid every cycle with SUB (req0: 10−3; req1: 3−10), `res_ready`=1:
  - Grants alternate 0,1,0,…
  - Results 0x0000_0007 and 0xFFFF_FFF9 with correct `res_id`.
- SHL from req1: a=0x0000_0003, shamt=4 → `res_valid` at T+5, `res_data`=0x0000_0030. SHL with shamt=0 → a returned at T+2.
- Backpressure: `res_ready`=0 for 10 cycles in DONE:
  - `res_data`/`res_id` stay stable.
  - `req_ready`=0 throughout and the pending req1 is not lost.
  - After `res_ready` pulses, req1 is accepted 2 cycles later.
- Assert `rst_n`=0 mid-SHL (shamt=20, at cycle 5 of EXEC):
  - All outputs go to 0 immediately, `busy`=0.
  - After release, req0 wins the first tie.
- Opcode 4'b0001 with a=5, b=5 → `res_data`=0 after the single-pass latency. NOT with a=0 → 0xFFFF_FFFF.
